// File: rtl/keypoint_stream_merge_pkg.sv
// keypoint_stream_merge_pkg: shared widths, layer tags, FSM codes and FIFO entry type
package keypoint_stream_merge_pkg;
  localparam int ADDR_W = 11;
  localparam int ROW_W  = 9;
  localparam int COL_W  = 10;
  localparam int KP_W   = ROW_W + COL_W;
  localparam int OUT_W  = 1 + KP_W;
  localparam logic [ADDR_W:0] ONE     = 1;
  localparam logic [ADDR_W:0] CNT_MAX = {1'b1, {ADDR_W{1'b0}}};
  localparam logic LAYER0 = 1'b0;
  localparam logic LAYER1 = 1'b1;
  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_COLLECT = 3'd1;
  localparam logic [2:0] S_DRAIN1  = 3'd2;
  localparam logic [2:0] S_DRAIN2  = 3'd3;
  localparam logic [2:0] S_FLUSH   = 3'd4;
  localparam logic [2:0] S_DONE    = 3'd5;
  typedef struct packed {
    logic            layer;
    logic            last;
    logic [KP_W-1:0] kp;
  } kp_entry_t;
endpackage

// File: rtl/keypoint_stream_merge_if.sv
// keypoint_stream_merge_if: valid/ready keypoint stream {layer,row,col} with last flag
//  master drives valid/data/last, slave drives ready
interface keypoint_stream_merge_if;
  import keypoint_stream_merge_pkg::*;
  logic             valid;
  logic             ready;
  logic             last;
  logic [OUT_W-1:0] data;
  modport master(output valid, data, last, input ready);
  modport slave(input valid, data, last, output ready);
endinterface

// File: rtl/keypoint_stream_merge_fifo.sv
// keypoint_stream_merge_fifo: 2-entry return-data FIFO (layer, last, row, col)
//  push/din write, pop advances head, dout is the head entry, count is occupancy
module keypoint_stream_merge_fifo
  import keypoint_stream_merge_pkg::*;
(
  input  logic      clk,
  input  logic      rst_n,
  input  logic      push,
  input  kp_entry_t din,
  input  logic      pop,
  output kp_entry_t dout,
  output logic [1:0] count
);
  kp_entry_t  mem_q [2];
  kp_entry_t  mem_d [2];
  logic       wp_q, wp_d, rp_q, rp_d;
  logic [1:0] cnt_q, cnt_d;
  always_comb begin
    mem_d = mem_q;
    mem_d[wp_q] = push ? din : mem_q[wp_q];
    wp_d = wp_q ^ push;
    rp_d = rp_q ^ pop;
    cnt_d = cnt_q + 2'(push) - 2'(pop);
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wp_q <= 1'b0;
      rp_q <= 1'b0;
      cnt_q <= 2'd0;
    end else begin
      mem_q <= mem_d;
      wp_q <= wp_d;
      rp_q <= rp_d;
      cnt_q <= cnt_d;
    end
  end
  assign dout = mem_q[rp_q];
  assign count = cnt_q;
endmodule

// File: rtl/keypoint_stream_merge.sv
// keypoint_stream_merge: counts snooped keypoint SRAM writes, then reads layer 0 then layer 1 back as one stream
//  start/detect_done frame control; kpN_we snooped strobes; kpN_re/raddr/rdata SRAM read ports
//  kp stream master; kpN_count/overflow frame counts; busy (not idle); done one-cycle drain-complete pulse
module keypoint_stream_merge
  import keypoint_stream_merge_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              detect_done,
  input  logic              kp1_we,
  input  logic              kp2_we,
  output logic              kp1_re,
  output logic [ADDR_W-1:0] kp1_raddr,
  input  logic [KP_W-1:0]   kp1_rdata,
  output logic              kp2_re,
  output logic [ADDR_W-1:0] kp2_raddr,
  input  logic [KP_W-1:0]   kp2_rdata,
  keypoint_stream_merge_if.master kp,
  output logic [ADDR_W:0]   kp1_count,
  output logic [ADDR_W:0]   kp2_count,
  output logic              overflow,
  output logic              busy,
  output logic              done
);
  logic [2:0]      state_q, state_d;
  logic [ADDR_W:0] cnt1_q, cnt1_d, cnt2_q, cnt2_d, ptr_q, ptr_d, cnt;
  logic            ovf_q, ovf_d, inf1_q, inf1_d, inf2_q, inf2_d, last_q, last_d;
  logic            draining, space, issue, ptr_last, pop, push;
  logic [1:0]      fc;
  kp_entry_t       head, push_e;
  keypoint_stream_merge_fifo u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .din   (push_e),
    .pop   (pop),
    .dout  (head),
    .count (fc)
  );
  assign kp.valid = fc != 2'd0;
  assign kp.data  = {head.layer, head.kp};
  assign kp.last  = kp.valid & head.last;
  // A pop this cycle frees a slot before the issued read returns, which keeps 1 word/cycle.
  always_comb begin
    pop = kp.valid & kp.ready;
    push = inf1_q | inf2_q;
    push_e = '{layer: inf2_q ? LAYER1 : LAYER0, last: last_q, kp: inf2_q ? kp2_rdata : kp1_rdata};
    draining = state_q == S_DRAIN1 || state_q == S_DRAIN2;
    space = (3'(fc) + 3'(inf1_q | inf2_q)) < (3'd2 + 3'(pop));
    cnt = state_q == S_DRAIN1 ? cnt1_q : cnt2_q;
    ptr_last = (ptr_q + ONE) == cnt;
    issue = draining && ptr_q < cnt && space;
    kp1_re = issue && state_q == S_DRAIN1;
    kp2_re = issue && state_q == S_DRAIN2;
    kp1_raddr = ptr_q[ADDR_W-1:0];
    kp2_raddr = ptr_q[ADDR_W-1:0];
    inf1_d = kp1_re;
    inf2_d = kp2_re;
    last_d = issue && ptr_last && (state_q == S_DRAIN2 || cnt2_q == '0);
    ptr_d = issue ? ptr_q + ONE : ptr_q;
    state_d = state_q;
    cnt1_d = cnt1_q;
    cnt2_d = cnt2_q;
    ovf_d = ovf_q;
    case (state_q)
      S_IDLE: if (start) begin
        state_d = S_COLLECT;
        cnt1_d = '0;
        cnt2_d = '0;
        ovf_d = 1'b0;
        ptr_d = '0;
      end
      S_COLLECT: begin
        cnt1_d = kp1_we && cnt1_q != CNT_MAX ? cnt1_q + ONE : cnt1_q;
        cnt2_d = kp2_we && cnt2_q != CNT_MAX ? cnt2_q + ONE : cnt2_q;
        ovf_d = ovf_q | (kp1_we && cnt1_q == CNT_MAX) | (kp2_we && cnt2_q == CNT_MAX);
        state_d = detect_done ? S_DRAIN1 : S_COLLECT;
      end
      S_DRAIN1: if (cnt == '0 || (issue && ptr_last)) begin
        state_d = S_DRAIN2;
        ptr_d = '0;
      end
      S_DRAIN2: state_d = cnt == '0 || (issue && ptr_last) ? S_FLUSH : S_DRAIN2;
      S_FLUSH: state_d = !push && fc == 2'd0 ? S_DONE : S_FLUSH;
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt1_q <= '0;
      cnt2_q <= '0;
      ptr_q <= '0;
      ovf_q <= 1'b0;
      inf1_q <= 1'b0;
      inf2_q <= 1'b0;
      last_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt1_q <= cnt1_d;
      cnt2_q <= cnt2_d;
      ptr_q <= ptr_d;
      ovf_q <= ovf_d;
      inf1_q <= inf1_d;
      inf2_q <= inf2_d;
      last_q <= last_d;
    end
  end
  assign kp1_count = cnt1_q;
  assign kp2_count = cnt2_q;
  assign overflow = ovf_q;
  assign busy = state_q != S_IDLE;
  assign done = state_q == S_DONE;
endmodule

// File: tb/tb_keypoint_stream_merge.sv
// tb_keypoint_stream_merge: randomized frames checked against a queue model of the expected word stream
module tb_keypoint_stream_merge;
  import keypoint_stream_merge_pkg::*;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, detect_done = 1'b0, kp1_we = 1'b0, kp2_we = 1'b0;
  logic kp1_re, kp2_re, overflow, busy, done;
  logic [ADDR_W-1:0] kp1_raddr, kp2_raddr;
  logic [KP_W-1:0] kp1_rdata = '0, kp2_rdata = '0;
  logic [ADDR_W:0] kp1_count, kp2_count;
  keypoint_stream_merge_if kp_if();
  keypoint_stream_merge dut (
    .clk(clk), .rst_n(rst_n), .start(start), .detect_done(detect_done),
    .kp1_we(kp1_we), .kp2_we(kp2_we),
    .kp1_re(kp1_re), .kp1_raddr(kp1_raddr), .kp1_rdata(kp1_rdata),
    .kp2_re(kp2_re), .kp2_raddr(kp2_raddr), .kp2_rdata(kp2_rdata),
    .kp(kp_if), .kp1_count(kp1_count), .kp2_count(kp2_count),
    .overflow(overflow), .busy(busy), .done(done)
  );
  always #5 clk = ~clk;
  logic [KP_W-1:0] sram1 [2048];
  logic [KP_W-1:0] sram2 [2048];
  always @(posedge clk) begin
    if (kp1_re) kp1_rdata <= sram1[kp1_raddr];
    if (kp2_re) kp2_rdata <= sram2[kp2_raddr];
  end
  int checks = 0, errors = 0, mode = 0, cyc_n = 0, first_pop = -1, last_pop = -1;
  bit re1_seen, re2_seen, valid_seen, hold;
  logic [OUT_W-1:0] hold_data;
  logic hold_last;
  logic [OUT_W:0] exp_q [$];
  logic [OUT_W:0] got_q [$];
  function automatic void chk(string name, logic [63:0] act, logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endfunction
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  initial begin
    kp_if.ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (mode)
        0: kp_if.ready = 1'b1;
        1: kp_if.ready = ~kp_if.ready;
        2: kp_if.ready = 1'($urandom_range(0, 1));
        default: kp_if.ready = 1'b0;
      endcase
    end
  end
  initial begin
    logic [OUT_W:0] e;
    forever begin
      @(negedge clk);
      cyc_n++;
      if (!rst_n) hold = 1'b0;
      else begin
        if (kp1_re) re1_seen = 1'b1;
        if (kp2_re) re2_seen = 1'b1;
        if (kp_if.valid) valid_seen = 1'b1;
        if (hold) chk("hold_stable", 64'({kp_if.valid, kp_if.last, kp_if.data}), 64'({1'b1, hold_last, hold_data}));
        if (kp_if.valid && kp_if.ready) begin
          if (exp_q.size() == 0) chk("extra_word", 64'({kp_if.last, kp_if.data}), 64'hDEAD_0000_0000_0000);
          else begin
            e = exp_q.pop_front();
            chk("word", 64'({kp_if.last, kp_if.data}), 64'(e));
          end
          got_q.push_back({kp_if.last, kp_if.data});
          if (first_pop < 0) first_pop = cyc_n;
          last_pop = cyc_n;
        end
        hold = kp_if.valid && !kp_if.ready;
        hold_data = kp_if.data;
        hold_last = kp_if.last;
      end
    end
  end
  task automatic chk_idle(string name);
    chk({name, "_stream"}, 64'({kp_if.valid, kp_if.last, kp_if.data}), 64'd0);
    chk({name, "_ctrl"}, 64'({kp1_re, kp2_re, kp1_raddr, kp2_raddr, overflow, busy, done}), 64'd0);
    chk({name, "_counts"}, 64'({kp1_count, kp2_count}), 64'd0);
  endtask
  task automatic begin_frame(input int n1, input int n2, input bit lit);
    int e1, e2, r1, r2;
    logic w1, w2;
    e1 = n1 > 2048 ? 2048 : n1;
    e2 = n2 > 2048 ? 2048 : n2;
    for (int i = 0; i < e1; i++) sram1[i] = KP_W'($urandom);
    for (int i = 0; i < e2; i++) sram2[i] = KP_W'($urandom);
    if (lit) begin
      sram1[0] = 19'h00A05;
      sram2[1] = 19'h7FFFF;
    end
    exp_q.delete();
    got_q.delete();
    re1_seen = 1'b0;
    re2_seen = 1'b0;
    valid_seen = 1'b0;
    first_pop = -1;
    last_pop = -1;
    for (int i = 0; i < e1; i++) exp_q.push_back({e2 == 0 && i == e1 - 1, 1'b0, sram1[i]});
    for (int i = 0; i < e2; i++) exp_q.push_back({i == e2 - 1, 1'b1, sram2[i]});
    start = 1'b1;
    tick;
    start = 1'b0;
    r1 = n1;
    r2 = n2;
    while (r1 + r2 > 0) begin
      w1 = r1 > 0 && $urandom_range(0, 3) != 0;
      w2 = r2 > 0 && $urandom_range(0, 3) != 0;
      kp1_we = w1;
      kp2_we = w2;
      r1 -= int'(w1);
      r2 -= int'(w2);
      detect_done = r1 == 0 && r2 == 0;
      tick;
    end
    if (n1 + n2 == 0) begin
      detect_done = 1'b1;
      tick;
    end
    kp1_we = 1'b0;
    kp2_we = 1'b0;
    detect_done = 1'b0;
    chk("kp1_count", 64'(kp1_count), 64'(e1));
    chk("kp2_count", 64'(kp2_count), 64'(e2));
    chk("overflow", 64'(overflow), 64'(n1 > 2048 || n2 > 2048));
  endtask
  task automatic finish_frame(input int n1, input int n2);
    int e1, e2, tot, cyc, budget;
    logic v1, v2;
    e1 = n1 > 2048 ? 2048 : n1;
    e2 = n2 > 2048 ? 2048 : n2;
    tot = e1 + e2;
    budget = tot * 4 + 40;
    cyc = 0;
    v1 = 1'b0;
    v2 = 1'b0;
    do begin
      kp1_we = 1'($urandom_range(0, 1));
      kp2_we = 1'($urandom_range(0, 1));
      tick;
      cyc++;
      if (cyc == 1) v1 = kp_if.valid;
      if (cyc == 2) v2 = kp_if.valid;
    end while (!done && cyc < budget);
    kp1_we = 1'b0;
    kp2_we = 1'b0;
    chk("done_seen", 64'(done), 64'd1);
    chk("all_words_out", 64'(exp_q.size()), 64'd0);
    if (tot == 0) begin
      chk("done_latency", 64'(cyc), 64'd3);
      chk("no_valid", 64'(valid_seen), 64'd0);
    end
    if (e1 == 0) chk("no_kp1_re", 64'(re1_seen), 64'd0);
    if (e2 == 0) chk("no_kp2_re", 64'(re2_seen), 64'd0);
    if (mode == 0 && e1 > 0) chk("first_valid_latency", 64'({v1, v2}), 64'b01);
    if (mode == 0 && tot > 0) chk("throughput", 64'(last_pop - first_pop), 64'(tot - 1));
    tick;
    chk("done_one_cycle", 64'({done, busy}), 64'd0);
    chk("counts_held", 64'({kp1_count, kp2_count, overflow}),
        64'({12'(e1), 12'(e2), 1'(n1 > 2048 || n2 > 2048)}));
  endtask
  initial begin
    int n1, n2;
    rst_n = 1'b0;
    repeat (3) tick;
    chk_idle("reset");
    rst_n = 1'b1;
    tick;
    mode = 0;
    begin_frame(3, 2, 1'b1);
    finish_frame(3, 2);
    chk("lit_words", 64'(got_q.size()), 64'd5);
    if (got_q.size() == 5) begin
      chk("lit_first", 64'(got_q[0]), 64'h00A05);
      chk("lit_fifth", 64'(got_q[4]), 64'h1FFFFF);
    end
    mode = 1;
    begin_frame(6, 4, 1'b0);
    finish_frame(6, 4);
    mode = 0;
    begin_frame(0, 0, 1'b0);
    finish_frame(0, 0);
    begin_frame(0, 4, 1'b0);
    finish_frame(0, 4);
    begin_frame(2049, 0, 1'b0);
    finish_frame(2049, 0);
    mode = 3;
    begin_frame(1, 5, 1'b0);
    repeat (5) tick;
    chk("stalled_in_drain2", 64'({busy, kp_if.valid}), 64'b11);
    rst_n = 1'b0;
    tick;
    chk_idle("mid_reset");
    rst_n = 1'b1;
    exp_q.delete();
    tick;
    mode = 0;
    begin_frame(2, 3, 1'b0);
    finish_frame(2, 3);
    for (int f = 0; f < 6; f++) begin
      mode = f % 3;
      n1 = $urandom_range(0, 12);
      n2 = $urandom_range(0, 12);
      begin_frame(n1, n2, 1'b0);
      finish_frame(n1, n2);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
